ext_irq_ctrl: RTL and testbench



---
 rtl/ext_irq_ctrl.sv | 120 ++++++++++++
 tb/tb_ext_irq_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ext_irq_ctrl.sv
// External interrupt front-end: per-source sync, level/edge pending latch, fixed-priority pick (index 0 wins).
// One registered request to the core. The claimed ID is held from ack until complete.
module ext_irq_ctrl #(
  parameter int unsigned        IRQ_NUM   = 8,
  parameter int unsigned        ID_W      = 3,
  parameter logic [IRQ_NUM-1:0] TRIG_EDGE = '0,
  parameter int unsigned        SYNC_EN   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IRQ_NUM-1:0] irq_src_i,
  input  logic [IRQ_NUM-1:0] irq_en_i,
  input  logic               irq_gbl_en_i,
  output logic               core_irq_o,
  input  logic               core_irq_ack_i,
  input  logic               irq_cmplt_i,
  output logic [ID_W-1:0]    irq_claim_id_o,
  output logic               irq_busy_o,
  output logic [IRQ_NUM-1:0] irq_pend_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SVC} state_e;

  state_e             state_q, state_d;
  logic [IRQ_NUM-1:0] sync_w, prev_q, pend_q, pend_d, cand, claim_clr;
  logic [ID_W-1:0]    id_q, id_d, win_id;
  logic               irq_q, irq_d, busy_q, busy_d;

  generate
    if (SYNC_EN != 0) begin : g_sync
      logic [IRQ_NUM-1:0] sync1_q, sync2_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1_q <= '0;
          sync2_q <= '0;
        end else begin
          sync1_q <= irq_src_i;
          sync2_q <= sync1_q;
        end
      end
      assign sync_w = sync2_q;
    end else begin : g_nosync
      assign sync_w = irq_src_i;
    end
  endgenerate

  assign cand = irq_gbl_en_i ? (pend_q & irq_en_i) : '0;

  always_comb begin
    win_id = '0;
    for (int i = int'(IRQ_NUM) - 1; i >= 0; i--) begin
      if (cand[i]) win_id = ID_W'(i);
    end
  end

  // A fresh rising edge in the claim cycle re-sets the bit, so set wins over clear.
  assign pend_d = (TRIG_EDGE & ((pend_q & ~claim_clr) | (sync_w & ~prev_q)))
                | (~TRIG_EDGE & sync_w);

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    irq_d     = 1'b0;
    busy_d    = 1'b0;
    claim_clr = '0;
    case (state_q)
      S_IDLE: begin
        if (cand != '0) begin
          state_d = S_REQ;
          id_d    = win_id;
          irq_d   = 1'b1;
        end
      end
      S_REQ: begin
        if (core_irq_ack_i) begin
          state_d   = S_SVC;
          busy_d    = 1'b1;
          claim_clr = TRIG_EDGE & (IRQ_NUM'(1) << id_q);
        end else if (cand == '0) begin
          state_d = S_IDLE;
        end else begin
          id_d  = win_id;
          irq_d = 1'b1;
        end
      end
      S_SVC: begin
        if (irq_cmplt_i) begin
          state_d = S_IDLE;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      irq_q   <= 1'b0;
      busy_q  <= 1'b0;
      prev_q  <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      irq_q   <= irq_d;
      busy_q  <= busy_d;
      prev_q  <= sync_w;
      pend_q  <= pend_d;
    end
  end

  assign core_irq_o     = irq_q;
  assign irq_busy_o     = busy_q;
  assign irq_claim_id_o = id_q;
  assign irq_pend_o     = pend_q;

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Bench for ext_irq_ctrl: directed handshake scenarios plus random traffic against a behavioural model.
module tb_ext_irq_ctrl;

  localparam logic [7:0] EDGE_MASK = 8'h25;  // sources 0, 2, 5 are edge-triggered

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] src = '0, en = 8'hff;
  logic       gbl = 1'b1, ack = 1'b0, cmplt = 1'b0;
  logic       core_irq, busy;
  logic [2:0] claim_id;
  logic [7:0] pend;

  int total = 0;
  int bad   = 0;

  ext_irq_ctrl #(.IRQ_NUM(8), .ID_W(3), .TRIG_EDGE(EDGE_MASK), .SYNC_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .irq_src_i(src), .irq_en_i(en), .irq_gbl_en_i(gbl),
    .core_irq_o(core_irq), .core_irq_ack_i(ack), .irq_cmplt_i(cmplt),
    .irq_claim_id_o(claim_id), .irq_busy_o(busy), .irq_pend_o(pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: raw samples, newest first; sync value = sample from two edges ago.
  logic [7:0] hist[$];
  int         m_phase;  // 0 idle, 1 requesting, 2 in service
  int         m_id;
  logic [7:0] m_pend;

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    hist = '{8'h00, 8'h00, 8'h00};
    m_phase = 0;
    m_id = 0;
    m_pend = '0;
  endtask

  task automatic model_edge();
    logic [7:0] sync_v, prev_v, cand;
    int w, claimed;
    sync_v  = hist[0+1];
    prev_v  = hist[2];
    cand    = gbl ? (m_pend & en) : 8'h00;
    w       = lowest(cand);
    claimed = -1;
    if (m_phase == 0) begin
      if (w >= 0) begin m_phase = 1; m_id = w; end
    end else if (m_phase == 1) begin
      if (ack) begin m_phase = 2; claimed = m_id; end
      else if (w < 0) m_phase = 0;
      else m_id = w;
    end else if (cmplt) begin
      m_phase = 0;
    end
    for (int i = 0; i < 8; i++) begin
      if (EDGE_MASK[i]) m_pend[i] = (sync_v[i] & ~prev_v[i]) | (m_pend[i] & (claimed != i));
      else              m_pend[i] = sync_v[i];
    end
    hist.push_front(src);
    void'(hist.pop_back());
  endtask

  task automatic cmp_model();
    chk("model_irq",  32'(core_irq), 32'(m_phase == 1));
    chk("model_busy", 32'(busy),     32'(m_phase == 2));
    chk("model_id",   32'(claim_id), 32'(m_id));
    chk("model_pend", 32'(pend),     32'(m_pend));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cmp_model();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    model_reset();
    #2;
    chk("rst_irq", 32'(core_irq), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_id", 32'(claim_id), 0);
    chk("rst_pend", 32'(pend), 0);
    #10 rst_n = 1'b1;

    // Level source 3: request three edges after sampling, re-request after completion
    src = 8'h08;
    steps(3);
    chk("lvl_pend", 32'(pend), 32'h08);
    chk("lvl_irq_early", 32'(core_irq), 0);
    step();
    chk("lvl_irq", 32'(core_irq), 1);
    chk("lvl_id", 32'(claim_id), 3);
    ack = 1'b1; step(); ack = 1'b0;
    chk("lvl_ack_busy", 32'(busy), 1);
    chk("lvl_ack_irq", 32'(core_irq), 0);
    cmplt = 1'b1; step(); cmplt = 1'b0;
    chk("lvl_idle_gap", 32'(core_irq | busy), 0);
    step();
    chk("lvl_rereq", 32'(core_irq), 1);
    chk("lvl_rereq_id", 32'(claim_id), 3);
    ack = 1'b1; step(); ack = 1'b0;
    src = 8'h00;
    steps(4);
    cmplt = 1'b1; step(); cmplt = 1'b0;
    steps(2);
    chk("lvl_quiet", 32'(core_irq), 0);

    // Edge sources 5 and 2 together: 2 first, then 5
    src = 8'h24; step(); src = 8'h00;
    steps(3);
    chk("edge_id_first", 32'(claim_id), 2);
    chk("edge_pend", 32'(pend), 32'h24);
    ack = 1'b1; step(); ack = 1'b0;
    chk("edge_ack_pend", 32'(pend), 32'h20);
    cmplt = 1'b1; step(); cmplt = 1'b0;
    step();
    chk("edge_next_irq", 32'(core_irq), 1);
    chk("edge_next_id", 32'(claim_id), 5);
    ack = 1'b1; step(); ack = 1'b0;
    cmplt = 1'b1; step(); cmplt = 1'b0;

    // Higher-priority arrival while requesting
    src = 8'h40; steps(4);
    chk("pre_id6", 32'(claim_id), 6);
    src = 8'h42; steps(4);
    chk("preempt_irq", 32'(core_irq), 1);
    chk("preempt_id", 32'(claim_id), 1);
    ack = 1'b1; step(); ack = 1'b0;
    chk("preempt_claim", 32'(claim_id), 1);
    src = 8'h00; steps(4);
    cmplt = 1'b1; step(); cmplt = 1'b0;

    // Withdrawal by disabling source 4, late ack ignored
    src = 8'h10; steps(4);
    chk("wd_irq", 32'(core_irq), 1);
    en = 8'hef; step();
    chk("wd_drop", 32'(core_irq), 0);
    ack = 1'b1; step(); ack = 1'b0;
    chk("wd_late_ack", 32'(busy), 0);
    src = 8'h00; steps(3);
    en = 8'hff; steps(2);
    chk("wd_quiet", 32'(core_irq), 0);

    // Edge source 0 re-triggers in its own ack cycle
    src = 8'h01; step(); src = 8'h00; steps(3);
    chk("re_id", 32'(claim_id), 0);
    src = 8'h01; step(); src = 8'h00; step();
    ack = 1'b1; step(); ack = 1'b0;
    chk("re_busy", 32'(busy), 1);
    chk("re_pend_kept", 32'(pend[0]), 1);
    cmplt = 1'b1; step(); cmplt = 1'b0;
    step();
    chk("re_rereq", 32'(core_irq), 1);
    chk("re_rereq_id", 32'(claim_id), 0);
    ack = 1'b1; step(); ack = 1'b0;
    cmplt = 1'b1; step(); cmplt = 1'b0;

    // Reset during service with a pending bit outstanding
    src = 8'h24; step(); src = 8'h00; steps(3);
    ack = 1'b1; step(); ack = 1'b0;
    chk("mid_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_outs", {28'h0, core_irq, busy, 2'b00}, 0);
    chk("mid_rst_id", 32'(claim_id), 0);
    chk("mid_rst_pend", 32'(pend), 0);
    #2 rst_n = 1'b1;
    steps(5);
    chk("post_rst_quiet", 32'(core_irq | (pend != 0)), 0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 5) == 0) src = src ^ (8'h01 << $urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) en = 8'($urandom);
      if ($urandom_range(0, 31) == 0) en = 8'hff;
      gbl   = ($urandom_range(0, 9) != 0);
      ack   = ($urandom_range(0, 3) == 0);
      cmplt = ($urandom_range(0, 4) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
